// File: rtl/flagram_scan_ctrl.sv
// flagram_scan_ctrl: sequences a flag RAM. Single-word writes are accepted while
// idle. A start request scans every address, classifies each returned word
// against the latched flag index, counts the matches and records the lowest
// matching address.
module flagram_scan_ctrl #(
  parameter int p_data_width    = 4,
  parameter int p_address_width = 4
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_reset,
  input  logic                       i_w_start,
  input  logic [3:0]                 i_w_flag_sel,
  input  logic                       i_w_wr_valid,
  input  logic [p_address_width-1:0] i_w_wr_address,
  input  logic [p_data_width-1:0]    i_w_wr_data,
  output logic                       o_w_wr_ready,
  output logic [p_address_width-1:0] o_w_ram_address,
  output logic [p_data_width-1:0]    o_w_ram_data,
  output logic                       o_w_ram_we,
  output logic                       o_w_ram_oe,
  input  logic [p_data_width-1:0]    i_w_ram_data,
  output logic                       o_w_busy,
  output logic                       o_w_done,
  output logic [p_address_width:0]   o_w_count,
  output logic                       o_w_found,
  output logic [p_address_width-1:0] o_w_first_addr
);

  localparam int AW = p_address_width;
  localparam int DW = p_data_width;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_SCAN, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ev_vld_q, ev_vld_d;     // RAM data this cycle belongs to ev_addr_q
  logic [AW-1:0]   ev_addr_q, ev_addr_d;
  logic [3:0]      sel_q, sel_d;
  logic [AW:0]     count_q, count_d;
  logic            found_q, found_d;
  logic [AW-1:0]   first_q, first_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   wd_q, wd_d;

  // Flag definitions assume a 4-bit word.
  function automatic logic flag_of(input logic [DW-1:0] d, input logic [3:0] sel);
    logic f;
    case (sel)
      4'd0:    f = (d != '0);
      4'd1:    f = d[3];
      4'd2:    f = ~^d;
      4'd3:    f = ^d;
      4'd4:    f = ~d[2];
      4'd5:    f = d[2];
      4'd6:    f = (d > 4'd4);
      4'd7:    f = (d < 4'd4);
      4'd8:    f = ((d & (d - 4'd1)) == '0);
      4'd9:    f = (d == 4'd7);
      4'd10:   f = (d == 4'd8);
      4'd11:   f = (d == 4'd15);
      4'd12:   f = (d[0] == d[3]) && (d[1] == d[2]);
      4'd13:   f = (d[3] == d[2]) || (d[2] == d[1]) || (d[1] == d[0]);
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // State and datapath registers; reset aborts any scan and clears results.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ev_vld_q  <= 1'b0;
      ev_addr_q <= '0;
      sel_q     <= '0;
      count_q   <= '0;
      found_q   <= 1'b0;
      first_q   <= '0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ev_vld_q  <= ev_vld_d;
      ev_addr_q <= ev_addr_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
      found_q   <= found_d;
      first_q   <= first_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
    end
  end

  // Next-state, address sequencing and match accumulation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ev_vld_d  = 1'b0;
    ev_addr_d = cnt_q;
    sel_d     = sel_q;
    count_d   = count_q;
    found_d   = found_q;
    first_d   = first_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    case (state_q)
      S_IDLE: begin
        if (i_w_wr_valid) begin
          // write wins; a coincident start is dropped
          wa_d    = i_w_wr_address;
          wd_d    = i_w_wr_data;
          state_d = S_WRITE;
        end else if (i_w_start) begin
          sel_d   = i_w_flag_sel;
          count_d = '0;
          found_d = 1'b0;
          first_d = '0;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_SCAN: begin
        ev_vld_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Read data lags the oe cycle by one; evaluate it against the previous address.
    if (ev_vld_q && flag_of(i_w_ram_data, sel_q)) begin
      count_d = count_q + 1'b1;
      if (!found_q) begin
        found_d = 1'b1;
        first_d = ev_addr_q;
      end
    end
  end

  // RAM port and status outputs decoded from state.
  always_comb begin
    o_w_wr_ready    = (state_q == S_IDLE);
    o_w_ram_we      = (state_q == S_WRITE);
    o_w_ram_oe      = (state_q == S_SCAN);
    o_w_ram_address = '0;
    o_w_ram_data    = '0;
    if (state_q == S_WRITE) begin
      o_w_ram_address = wa_q;
      o_w_ram_data    = wd_q;
    end else if (state_q == S_SCAN) begin
      o_w_ram_address = cnt_q;
    end
    o_w_busy       = (state_q != S_IDLE);
    o_w_done       = (state_q == S_DONE);
    o_w_count      = count_q;
    o_w_found      = found_q;
    o_w_first_addr = first_q;
  end

endmodule

// File: tb/tb_flagram_scan_ctrl.sv
// Bench for flagram_scan_ctrl: behavioural flag RAM, directed stimulus,
// scoreboard queue of expected scan results checked by a done monitor.
module tb_flagram_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] flag_sel = '0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_ready, ram_we, ram_oe, busy, done, found;
  logic [3:0] ram_addr, ram_din, first_addr;
  logic [3:0] ram_q;
  logic [4:0] count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    string name;
    int    cnt;
    int    fnd;
    int    first;
    int    at;
  } exp_t;
  exp_t sb[$];

  flagram_scan_ctrl #(.p_data_width(4), .p_address_width(4)) dut (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start), .i_w_flag_sel(flag_sel),
    .i_w_wr_valid(wr_valid), .i_w_wr_address(wr_addr), .i_w_wr_data(wr_data),
    .o_w_wr_ready(wr_ready), .o_w_ram_address(ram_addr), .o_w_ram_data(ram_din),
    .o_w_ram_we(ram_we), .o_w_ram_oe(ram_oe), .i_w_ram_data(ram_q),
    .o_w_busy(busy), .o_w_done(done), .o_w_count(count), .o_w_found(found),
    .o_w_first_addr(first_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flag RAM model: synchronous write, registered read valid one cycle after oe.
  logic [3:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_oe) ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_count"}, int'(count), e.cnt);
        chk({e.name, "_found"}, int'(found), e.fnd);
        chk({e.name, "_first"}, int'(first_addr), e.first);
        chk({e.name, "_latency"}, cyc, e.at);
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic scan(input string name, input logic [3:0] sel, input int c,
                      input int f, input int fa, input bit push);
    @(negedge clk);
    start = 1'b1; flag_sel = sel;
    if (push) sb.push_back('{name, c, f, fa, cyc + 18});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ready", int'(wr_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we_oe", int'({ram_we, ram_oe}), 0);
    chk("rst_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) wr(4'(i), 4'(i));
    @(negedge clk);
    chk("fill_word9", int'(mem[9]), 9);

    scan("pow2", 4'd8, 5, 1, 0, 1'b1);   wait_idle();
    scan("eq15", 4'd11, 1, 1, 15, 1'b1); wait_idle();
    scan("zero14", 4'd14, 0, 0, 0, 1'b1); wait_idle();
    scan("nz", 4'd0, 15, 1, 1, 1'b1);    wait_idle();
    scan("odd", 4'd3, 8, 1, 1, 1'b1);    wait_idle();
    scan("gt4", 4'd6, 11, 1, 5, 1'b1);   wait_idle();
    scan("adj", 4'd13, 14, 1, 0, 1'b1);  wait_idle();
    scan("mirror", 4'd12, 4, 1, 0, 1'b1); wait_idle();

    // reset while scanning address 7
    scan("abort", 4'd8, 0, 0, 0, 1'b0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
        if (ram_oe && ram_addr == 4'd7) hit = 1'b1;
        else @(negedge clk);
      end
      chk("abort_reach_addr7", int'(hit), 1);
    end
    chk("abort_partial_count", int'(count), 4);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(wr_ready), 1);
    chk("abort_count", int'(count), 0);
    chk("abort_found", int'(found), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_ram_kept", int'(mem[12]), 12);

    // flag_sel changes mid-scan; latched value must be used
    scan("selhold", 4'd8, 5, 1, 0, 1'b1);
    repeat (4) @(negedge clk);
    flag_sel = 4'd9;
    wait_idle();

    // write attempt during scan is ignored
    scan("wrbusy", 4'd8, 5, 1, 0, 1'b1);
    repeat (3) @(negedge clk);
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 4'hA;
    #1 chk("wrbusy_ready", int'(wr_ready), 0);
    @(negedge clk);
    chk("wrbusy_we", int'(ram_we), 0);
    wr_valid = 1'b0;
    wait_idle();
    chk("wrbusy_word3", int'(mem[3]), 3);

    // simultaneous start and write: write only
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 4'd9; start = 1'b1; flag_sel = 4'd0;
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b0;
    chk("both_we", int'(ram_we), 1);
    chk("both_oe", int'(ram_oe), 0);
    @(negedge clk);
    chk("both_idle", int'(busy), 0);
    chk("both_word5", int'(mem[5]), 9);
    repeat (3) @(negedge clk);
    chk("both_noscan", int'(busy), 0);

    // all words 7, count saturates at 16
    for (int i = 0; i < 16; i++) wr(4'(i), 4'h7);
    scan("all7", 4'd9, 16, 1, 0, 1'b1); wait_idle();
    repeat (3) @(negedge clk);
    chk("all7_hold", int'(count), 16);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
